// File: rtl/tt_um_adder8.sv
// 8-bit unsigned ripple-carry adder in the user-tile wrapper; SUM = (A + B) mod 256.
// Define OUTPUT_REG_EN to register the sum (1-cycle latency, sync reset, ena-gated load).
module tt_um_adder8_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module tt_um_adder8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [8:0] carry;
    logic [7:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        tt_um_adder8_fa u_fa (
            .a  (ui_in[i]),
            .b  (uio_in[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Bidirectional pins are inputs only.
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

`ifdef OUTPUT_REG_EN
    logic [7:0] sum_d;
    logic [7:0] sum_q;

    always_comb begin
        sum_d = sum_q;
        if (ena) begin
            sum_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign uo_out = sum_q;

    // Carry-out is dropped so the result wraps.
    logic unused_ok;
    assign unused_ok = &{1'b0, carry[8]};
`else
    assign uo_out = sum;

    // Carry-out is dropped; clk/rst/ena have no role in the combinational build.
    logic unused_ok;
    assign unused_ok = &{1'b0, carry[8], clk, rst, ena};
`endif
endmodule

// File: tb/tb_tt_um_adder8.sv
// Self-checking bench for tt_um_adder8: vector table, random/exhaustive sweep against
// a plain-arithmetic model, and register-mode sequences when OUTPUT_REG_EN is defined.
module tb_tt_um_adder8;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t vecs[8];

    tt_um_adder8 dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b);
        int full;
        full = int'(a) + int'(b);
        return 8'(full % 256);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

`ifdef OUTPUT_REG_EN
    logic [7:0] model_q = 8'h00;

    // Drive at negedge, let one rising edge happen, observe 1 ns later.
    task automatic step(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r; ena = e; ui_in = a; uio_in = b;
        @(posedge clk);
        if (r) model_q = 8'h00;
        else if (e) model_q = model_sum(a, b);
        #1;
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        step(1'b0, 1'b1, a, b);
    endtask
`else
    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        ui_in = a; uio_in = b;
        #1;
    endtask
`endif

    initial begin
        vecs[0] = '{8'h0C, 8'h07, 8'h13};
        vecs[1] = '{8'hF0, 8'h0F, 8'hFF};
        vecs[2] = '{8'hAA, 8'h55, 8'hFF};
        vecs[3] = '{8'hFF, 8'h01, 8'h00};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFE};
        vecs[5] = '{8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'h80, 8'h80, 8'h00};
        vecs[7] = '{8'h7F, 8'h01, 8'h80};

        rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

`ifdef OUTPUT_REG_EN
        ui_in = 8'h5A; uio_in = 8'h33;
        @(posedge clk); @(posedge clk); #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);

        @(negedge clk);
        rst = 1'b0; ena = 1'b1; ui_in = 8'h0C; uio_in = 8'h07;
        #1;
        check("latency_not_before_edge", uo_out, 8'h00);
        @(posedge clk); #1;
        check("latency_after_edge", uo_out, 8'h13);
        model_q = 8'h13;

        step(1'b0, 1'b0, 8'hFF, 8'h01);
        check("hold_when_ena_low", uo_out, 8'h13);

        step(1'b0, 1'b1, 8'hFF, 8'h01);
        check("mid_wrap", uo_out, 8'h00);
        step(1'b0, 1'b1, 8'h10, 8'h20);
        check("mid_load", uo_out, 8'h30);
        step(1'b1, 1'b1, 8'h10, 8'h20);
        check("mid_reset", uo_out, 8'h00);
        step(1'b0, 1'b1, 8'h10, 8'h20);
        check("mid_release", uo_out, 8'h30);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), uo_out, vecs[i].exp_sum);
        end

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
            check("rand_reg", uo_out, model_q);
            check("rand_uio_oe", uio_oe, 8'h00);
        end
`else
        #1;
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        ui_in = 8'h0C; uio_in = 8'h07;
        #10;
        check("hold_10ns", uo_out, 8'h13);
        rst = 1'b0; ena = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), uo_out, vecs[i].exp_sum);
            check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'h00);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            apply(a, b);
            check("rand", uo_out, model_sum(a, b));
        end

        // Control inputs and clock edges must not disturb the result.
        apply(8'h3C, 8'h4B);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'($urandom_range(0, 1));
            ena = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("ctrl_toggle", uo_out, 8'h87);
            check("ctrl_uio_out", uio_out, 8'h00);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                apply(8'(a), 8'(b));
                check("exhaustive", uo_out, model_sum(8'(a), 8'(b)));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tt_um_adder8.md
Name: tt_um_adder8

Overview:
- 8-bit unsigned parallel (ripple-carry) adder in the standard user-tile wrapper.
- Operand A arrives on the dedicated inputs, operand B on the bidirectional pins used as inputs, and SUM[7:0] leaves on the dedicated outputs.
- Carry-out is computed internally and discarded, so the result wraps modulo 256.
- The bidirectional pins are never driven.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; used only when OUTPUT_REG_EN is defined.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  design-selected enable; high = active.
- ui_in  input  8  operand A, unsigned.
- uio_in  input  8  operand B, unsigned.
- uo_out  output  8  SUM = (A + B) mod 256.
- uio_out  output  8  tied to 8'h00.
- uio_oe  output  8  tied to 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Datapath structure:
  - Eight 1-bit full adders in a ripple chain, built as a generate loop of full-adder cells.
  - c[0] = 0.
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
- Width rule: c[8] (carry-out) is computed but is not output. Overflow wraps: 255 + 1 = 0; 255 + 255 = 254.
- Default build (OUTPUT_REG_EN undefined):
  - uo_out = s[7:0], purely combinational, zero-cycle latency.
  - Output settles within the same simulation step as the input change.
  - clk, rst and ena do not affect uo_out.
- uio_out and uio_oe are constant 0 in all modes, including during reset.
- No state machine and no handshake: each input change produces a new result.
- Unknown or X inputs propagate to the output; no sanitising.
- Unused-input lint sinks are required for ena, clk and rst in the default build.

Optional Feature:
- Macro: OUTPUT_REG_EN.
- When defined:
  - uo_out is driven from an 8-bit register sum_q, updated on the rising edge of clk.
  - If rst = 1 at the edge, sum_q <= 8'h00; rst has priority over ena.
  - Else if ena = 1 at the edge, sum_q <= s[7:0].
  - Else sum_q holds its value.
  - Latency is 1 clock: the result of inputs sampled at edge N is visible after edge N.
  - Reset applied mid-operation clears uo_out to 0x00 at the next edge, regardless of the inputs.
  - Inputs that change between edges have no effect until the next edge.
- When undefined: combinational behaviour as described in Behaviour; no flops exist in the design.

Test Plan:
- Default build, A=0x0C, B=0x07, hold 10 ns -> uo_out=0x13 (19); uio_out=0x00, uio_oe=0x00.
- A=0xF0, B=0x0F -> uo_out=0xFF (no carry propagation). A=0xAA, B=0x55 -> uo_out=0xFF.
- A=0xFF, B=0x01 -> uo_out=0x00 (full carry ripple, carry-out dropped). A=0xFF, B=0xFF -> 0xFE. A=0x00, B=0x00 -> 0x00.
- Random sweep of 1000 pairs (plus exhaustive 65536 if affordable) -> uo_out == (A+B)&0xFF every vector. Toggling ena, rst or clk has no effect in the default build.
- OUTPUT_REG_EN:
  - rst=1 for 2 edges -> uo_out=0x00.
  - Release rst, ena=1, A=0x0C, B=0x07 -> uo_out=0x13 one edge later, not before.
  - ena=0, change A to 0xFF, B to 0x01 -> uo_out holds 0x13.
- OUTPUT_REG_EN mid-operation reset: ena=1, A=0xFF, B=0x01, run one edge -> uo_out=0x00.
  - A=0x10, B=0x20, run one edge -> uo_out=0x30.
  - Assert rst for 1 edge with A and B unchanged -> uo_out=0x00.
  - Deassert rst -> uo_out=0x30 after the next edge.
